pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall and flush sequencer for the five-stage in-order pipeline. It merges the load-use stall from the hazard detector, instruction- and data-cache busy signals, EX-stage branch redirects and a halt request. From these it drives per-stage pipeline-register enables, bubble-inject (flush) controls, a drain/halt state machine and two performance counters. It sits beside the hazard detector and is the only block that drives pipeline-register enables.

## Interface
- `CNT_WIDTH`, 32, width of each performance counter
- `DRAIN_DEPTH`, 3, advancing cycles needed for a halt instruction in ID/EX to retire
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `ld_use_stall`  in  1  load-use hazard between EX load and ID instruction
- `icache_busy`  in  1  fetch miss outstanding; IF has no valid instruction this cycle
- `dcache_busy`  in  1  MEM-stage access outstanding
- `redirect_valid`  in  1  EX resolved a taken branch/jump or mispredict; held by EX until accepted
- `halt_req`  in  1  halt instruction is in ID
- `pc_en`  out  1  PC register load enable
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  pipeline-register enables
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble instead of upstream contents (effective only when the matching enable is 1)
- `halted`  out  1  pipeline drained and stopped
- `stall_cycles`  out  CNT_WIDTH  RUN cycles with `pc_en`=0
- `redirect_count`  out  CNT_WIDTH  accepted redirects

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- An internal drain counter spans 0..DRAIN_DEPTH-1.
- All outputs are combinational from state and inputs. State and counters update on the `clk` rising edge.
- Action priority each cycle, highest first:
  1. **Freeze** (`dcache_busy`=1): all enables 0, all flushes 0. No state or counter change except `stall_cycles` in RUN.
  2. **Redirect** (`redirect_valid`=1, not frozen, state RUN or DRAIN): `pc_en`=1 and all stage enables 1. `if_id_flush`=1 and `id_ex_flush`=1. `redirect_count`+1. Next state is RUN, because the redirect squashes a younger halt in DRAIN. The drain counter clears.
  3. **Load-use** (`ld_use_stall`=1, RUN): `pc_en`=0, `if_id_en`=0. `id_ex_en`=1 with `id_ex_flush`=1. `ex_mem_en`=1, `mem_wb_en`=1.
  4. **Halt accept** (`halt_req`=1, RUN): all enables 1, `if_id_flush`=0. Next state DRAIN, counter 0. Fetch still advances this cycle; the fetched instruction is discarded by DRAIN.
  5. **Fetch miss** (`icache_busy`=1, RUN): `pc_en`=0. `if_id_en`=1 with `if_id_flush`=1. All other enables 1.
  6. **Normal**: all enables 1, flushes 0.
- DRAIN, when not frozen and no redirect:
  - `pc_en`=0. `if_id_en`=1 with `if_id_flush`=1. All other enables 1.
  - `ld_use_stall`, `halt_req` and `icache_busy` are ignored.
  - The counter increments. At count DRAIN_DEPTH-1 the next state is HALTED.
- HALTED: all enables 0, flushes 0, `halted`=1. All inputs are ignored; only `reset` exits.
- `halt_req` coincident with `ld_use_stall`: load-use wins and the halt is not accepted. ID holds, so `halt_req` repeats next cycle.
- Counters wrap modulo 2^CNT_WIDTH. `stall_cycles` counts every RUN cycle with `pc_en`=0, including freeze, load-use and fetch-miss cycles.

## Timing
- Controls are valid in the same cycle as inputs. There are no registered outputs apart from `halted`, `stall_cycles` and `redirect_count`.
- Load-use inserts exactly one bubble per asserted cycle.
- Redirect penalty: 2 bubbles (IF/ID and ID/EX), applied in the accept cycle.
- Halt latency: `halted`=1 exactly DRAIN_DEPTH+1 unfrozen cycles after the accept cycle's edge; freeze cycles extend this one-for-one.
- While `reset`=1: all enables 0, `if_id_flush`=1, `id_ex_flush`=1, `halted`=0.
- Reset effects at the next edge: state RUN, drain counter 0, both counters 0. Reset mid-DRAIN or mid-HALTED returns to RUN with no residual state.

## Structure
- Package `pipeline_pkg` holds:
  - `ctrl_state_e` enum (RUN, DRAIN, HALTED)
  - `DRAIN_DEPTH` default
  - a packed `stage_ctrl_t` struct bundling the enables and flushes
- Sub-module `event_counter`: parameterised width; increment enable; synchronous reset; wraps. It is instantiated twice.

## Test plan
- Reset held 2 cycles, then `ld_use_stall`=1 for 1 cycle → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 that cycle; next cycle all enables 1; `stall_cycles`=1.
- `dcache_busy`=1 for 5 cycles with `redirect_valid`=1 → all enables 0 for 5 cycles. On cycle 6 the redirect is accepted with both flushes=1; `redirect_count`=1 and `stall_cycles`=5.
- `halt_req` for 1 cycle, no other inputs → DRAIN for 3 cycles with `pc_en`=0; `halted`=1 on the 4th cycle after accept and stays 1 for 20 cycles regardless of inputs.
- Halt accepted, then `redirect_valid`=1 in the 2nd DRAIN cycle → both flushes=1, state RUN, `halted` never rises.
- `halt_req`=1 and `ld_use_stall`=1 together → load-use action and state stays RUN; next cycle `halt_req` alone → DRAIN.
- `reset` asserted in HALTED and in DRAIN with `stall_cycles`=0xFFFFFFFF → next cycle RUN, `halted`=0, counters 0. A separate run shows `stall_cycles` wrapping from 0xFFFFFFFF to 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_e;

  localparam int unsigned DEFAULT_DRAIN_DEPTH = 3;

  // Per-stage register enables and bubble-inject controls, MSB first.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FROZEN   = '{default: 1'b0};
  localparam stage_ctrl_t CTRL_RESET    = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                            ex_mem_en: 1'b0, mem_wb_en: 1'b0,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_ADVANCE  = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam stage_ctrl_t CTRL_REDIRECT = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                            ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b1};
  // Hold PC, push a bubble into IF/ID, let everything downstream advance.
  localparam stage_ctrl_t CTRL_IF_BUBBLE = '{pc_en: 1'b0, if_id_en: 1'b1, id_ex_en: 1'b1,
                                             ex_mem_en: 1'b1, mem_wb_en: 1'b1,
                                             if_id_flush: 1'b1, id_ex_flush: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_event_counter.sv
// Free-running wrap-around event counter with synchronous reset.
module event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count enabled events; wraps naturally at 2^WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: per-stage enables, bubble injects,
// drain/halt FSM and stall/redirect performance counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned DRAIN_DEPTH = DEFAULT_DRAIN_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_use_stall,
  input  logic                 icache_busy,
  input  logic                 dcache_busy,
  input  logic                 redirect_valid,
  input  logic                 halt_req,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  localparam int unsigned DCW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_DEPTH - 1);

  ctrl_state_e    state, state_nx;
  logic [DCW-1:0] drain_cnt, drain_cnt_nx;
  stage_ctrl_t    ctrl;
  logic           stall_inc;
  logic           redirect_inc;

  // State and drain counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
    end
  end

  // Prioritised action select: reset, halted, freeze, redirect, drain, then RUN hazards.
  always_comb begin
    ctrl         = CTRL_FROZEN;
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    redirect_inc = 1'b0;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (state == HALTED || dcache_busy) begin
      ctrl = CTRL_FROZEN;
    end else if (redirect_valid) begin
      // A redirect out of DRAIN squashes the younger halt and resumes fetch.
      ctrl         = CTRL_REDIRECT;
      redirect_inc = 1'b1;
      state_nx     = RUN;
      drain_cnt_nx = '0;
    end else if (state == DRAIN) begin
      ctrl = CTRL_IF_BUBBLE;
      if (drain_cnt == DRAIN_LAST) begin
        state_nx     = HALTED;
        drain_cnt_nx = '0;
      end else begin
        drain_cnt_nx = drain_cnt + DCW'(1);
      end
    end else if (ld_use_stall) begin
      ctrl = CTRL_LOAD_USE;
    end else if (halt_req) begin
      ctrl         = CTRL_ADVANCE;
      state_nx     = DRAIN;
      drain_cnt_nx = '0;
    end else if (icache_busy) begin
      ctrl = CTRL_IF_BUBBLE;
    end else begin
      ctrl = CTRL_ADVANCE;
    end
    stall_inc = !reset && (state == RUN) && !ctrl.pc_en;
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  // Masked during reset so it drops in the same cycle reset is raised.
  assign halted      = (state == HALTED) && !reset;

  event_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  event_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect_inc),
    .count (redirect_count)
  );

endmodule
